// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Optional alignment checking is enabled with the DM_ARB_ALIGN_CHK_EN macro.
package dm_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic REQ_R0 = 1'b0;
  localparam logic REQ_R1 = 1'b1;

  localparam int HOLD_W = 4;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and data-memory signals of dm_arbiter, bundled as one interface.
// slave: the arbiter's view; master: the requesters plus DM model driving it.
interface dm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic [31:0]       r0_pc;
  logic              r0_ack;
  logic [DATA_W-1:0] r0_rdata;
  logic              r0_err;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic [31:0]       r1_pc;
  logic              r1_ack;
  logic [DATA_W-1:0] r1_rdata;
  logic              r1_err;

  logic              MemWrite;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemData;
  logic [31:0]       pc;
  logic [DATA_W-1:0] ReadData;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_pc,
    output r0_ack, r0_rdata, r0_err,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_pc,
    output r1_ack, r1_rdata, r1_err,
    output MemWrite, MemAddr, MemData, pc,
    input  ReadData
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r0_pc,
    input  r0_ack, r0_rdata, r0_err,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_pc,
    input  r1_ack, r1_rdata, r1_err,
    input  MemWrite, MemAddr, MemData, pc,
    output ReadData
  );

endinterface

// File: rtl/dm_arb_pick.sv
// Combinational winner selection: r0 has priority unless r1 has waited
// through MAX_HOLD consecutive r0 grants.
module dm_arb_pick
  import dm_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic              i_r0_req,
  input  logic              i_r1_req,
  input  logic [HOLD_W-1:0] i_hold_cnt,
  output logic              o_grant_valid,
  output logic              o_grant_id
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

  logic w_r1_turn;

  assign w_r1_turn     = i_r1_req & (~i_r0_req | (i_hold_cnt == MAX_HOLD_C));
  assign o_grant_valid = i_r0_req | i_r1_req;
  assign o_grant_id    = w_r1_turn ? REQ_R1 : REQ_R0;

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter serialising r0 (CPU) and r1 (debug/loader) onto the DM.
// Define DM_ARB_ALIGN_CHK_EN to reject word-unaligned addresses with err.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input logic          clk,
  input logic          reset,
  dm_arbiter_if.slave  bus
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_we_q;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [DATA_W-1:0]   r_wdata_q;
  logic [31:0]         r_pc_q;
  logic                r_id_q;
  logic                r_err_q;

  logic                w_grant_valid;
  logic                w_grant_id;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [31:0]         w_sel_pc;
  logic                w_sel_err;
  logic                w_serve;
  logic [DATA_W-1:0]   w_rdata;

  dm_arb_pick #(
    .MAX_HOLD (MAX_HOLD)
  ) u_pick (
    .i_r0_req      (bus.r0_req),
    .i_r1_req      (bus.r1_req),
    .i_hold_cnt    (r_hold_cnt),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  assign w_sel_we    = (w_grant_id == REQ_R1) ? bus.r1_we    : bus.r0_we;
  assign w_sel_addr  = (w_grant_id == REQ_R1) ? bus.r1_addr  : bus.r0_addr;
  assign w_sel_wdata = (w_grant_id == REQ_R1) ? bus.r1_wdata : bus.r0_wdata;
  assign w_sel_pc    = (w_grant_id == REQ_R1) ? bus.r1_pc    : bus.r0_pc;

`ifdef DM_ARB_ALIGN_CHK_EN
  assign w_sel_err = (w_sel_addr[1:0] != 2'b00);
`else
  assign w_sel_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_we_q     <= 1'b0;
      r_addr_q   <= '0;
      r_wdata_q  <= '0;
      r_pc_q     <= '0;
      r_id_q     <= REQ_R0;
      r_err_q    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_state   <= SERVE;
            r_id_q    <= w_grant_id;
            r_we_q    <= w_sel_we;
            r_addr_q  <= w_sel_addr;
            r_wdata_q <= w_sel_wdata;
            r_pc_q    <= w_sel_pc;
            r_err_q   <= w_sel_err;
            // Count r0 wins only while r1 is actually waiting.
            if (w_grant_id == REQ_R0 && bus.r1_req) begin
              if (r_hold_cnt != MAX_HOLD_C) r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
              r_hold_cnt <= '0;
            end
          end
        end
        SERVE:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset during SERVE must suppress both the DM write and the ack.
  assign w_serve = (r_state == SERVE) & ~reset;
  assign w_rdata = (w_serve & ~r_err_q) ? bus.ReadData : '0;

  assign bus.MemWrite = w_serve & r_we_q & ~r_err_q;
  assign bus.MemAddr  = w_serve ? r_addr_q  : '0;
  assign bus.MemData  = w_serve ? r_wdata_q : '0;
  assign bus.pc       = w_serve ? r_pc_q    : '0;

  assign bus.r0_ack   = w_serve & (r_id_q == REQ_R0);
  assign bus.r1_ack   = w_serve & (r_id_q == REQ_R1);
  assign bus.r0_rdata = bus.r0_ack ? w_rdata : '0;
  assign bus.r1_rdata = bus.r1_ack ? w_rdata : '0;

`ifdef DM_ARB_ALIGN_CHK_EN
  assign bus.r0_err = bus.r0_ack & r_err_q;
  assign bus.r1_err = bus.r1_ack & r_err_q;
`else
  assign bus.r0_err = 1'b0;
  assign bus.r1_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a word-addressed DM model.
// Scenario 5 expectations follow DM_ARB_ALIGN_CHK_EN when it is defined.
module tb_dm_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] mem [0:255];

  dm_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dm_arbiter #(
    .MAX_HOLD (4),
    .ADDR_W   (32),
    .DATA_W   (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ReadData = mem[bus.MemAddr[9:2]];

  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.MemAddr[9:2]] <= bus.MemData;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {59'd0, bus.MemWrite, bus.r0_ack, bus.r1_ack, bus.r0_err, bus.r1_err}, 64'd0);
    chk({tag, "_dat"}, {bus.r0_rdata, bus.r1_rdata}, 64'd0);
    chk({tag, "_adr"}, {bus.MemAddr, bus.pc}, 64'd0);
  endtask

  task automatic r0_set(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pcv);
    bus.r0_req = req; bus.r0_we = we; bus.r0_addr = addr;
    bus.r0_wdata = wdata; bus.r0_pc = pcv;
  endtask

  task automatic r1_set(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pcv);
    bus.r1_req = req; bus.r1_we = we; bus.r1_addr = addr;
    bus.r1_wdata = wdata; bus.r1_pc = pcv;
  endtask

  initial begin
    logic [1:0] exp_ack;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    reset = 1'b1;
    r0_set(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    r1_set(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    // Reset state
    step();
    step();
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_hold", {60'd0, dut.r_hold_cnt}, 64'd0);
    step();
    reset = 1'b0;
    step();

    // 1: r0 store
    r0_set(1'b1, 1'b1, 32'h0000_0078, 32'hf00f_0ff0, 32'h0000_3000);
    @(negedge clk);
    chk("s1_T_memwrite", {63'd0, bus.MemWrite}, 64'd0);
    chk("s1_T_ack", {63'd0, bus.r0_ack}, 64'd0);
    step();
    @(negedge clk);
    chk("s1_memwrite", {63'd0, bus.MemWrite}, 64'd1);
    chk("s1_memaddr", {32'd0, bus.MemAddr}, 64'h78);
    chk("s1_memdata", {32'd0, bus.MemData}, 64'hf00f_0ff0);
    chk("s1_pc", {32'd0, bus.pc}, 64'h3000);
    chk("s1_acks", {62'd0, bus.r1_ack, bus.r0_ack}, 64'b01);
    $display("txn s1 r0 store addr=%h data=%h", bus.MemAddr, bus.MemData);
    step();
    r0_set(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk_quiet("s1_after");

    // 2: r1 load of the word just stored
    step();
    r1_set(1'b1, 1'b0, 32'h0000_0078, 32'd0, 32'h0000_0000);
    @(negedge clk);
    chk("s2_T_acks", {62'd0, bus.r1_ack, bus.r0_ack}, 64'd0);
    step();
    @(negedge clk);
    chk("s2_acks", {62'd0, bus.r1_ack, bus.r0_ack}, 64'b10);
    chk("s2_rdata", {32'd0, bus.r1_rdata}, 64'hf00f_0ff0);
    chk("s2_memwrite", {63'd0, bus.MemWrite}, 64'd0);
    $display("txn s2 r1 load rdata=%h", bus.r1_rdata);
    step();
    r1_set(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    // 3: both requesting for 24 cycles; r1 every fifth grant
    r0_set(1'b1, 1'b0, 32'h0000_0078, 32'd0, 32'h0000_3004);
    r1_set(1'b1, 1'b0, 32'h0000_0080, 32'd0, 32'h0000_0000);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c % 2 == 0) begin
        chk($sformatf("s3_idle_c%0d", c), {62'd0, bus.r1_ack, bus.r0_ack}, 64'd0);
      end else begin
        exp_ack = ((c / 2) % 5 == 4) ? 2'b10 : 2'b01;
        chk($sformatf("s3_ack_c%0d", c), {62'd0, bus.r1_ack, bus.r0_ack}, {62'd0, exp_ack});
        chk($sformatf("s3_rd_c%0d", c), {bus.r0_rdata, bus.r1_rdata},
            exp_ack[0] ? 64'hf00f_0ff0_0000_0000 : 64'd0);
        $display("txn s3 #%0d acks r1r0=%b%b", c / 2, bus.r1_ack, bus.r0_ack);
      end
      step();
    end
    r0_set(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    r1_set(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    // 4: reset during SERVE kills the store; held request is reissued
    step();
    r0_set(1'b1, 1'b1, 32'h0000_0040, 32'ha5a5_5a5a, 32'h0000_3020);
    @(negedge clk);
    chk("s4_T_ack", {63'd0, bus.r0_ack}, 64'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("s4_rst_memwrite", {63'd0, bus.MemWrite}, 64'd0);
    chk("s4_rst_ack", {63'd0, bus.r0_ack}, 64'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("s4_idle_ctl", {62'd0, bus.MemWrite, bus.r0_ack}, 64'd0);
    chk("s4_no_write", {32'd0, mem[16]}, 64'd0);
    step();
    @(negedge clk);
    chk("s4_re_memwrite", {63'd0, bus.MemWrite}, 64'd1);
    chk("s4_re_addr", {32'd0, bus.MemAddr}, 64'h40);
    chk("s4_re_ack", {63'd0, bus.r0_ack}, 64'd1);
    $display("txn s4 r0 reissued store addr=%h", bus.MemAddr);
    step();
    r0_set(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("s4_mem", {32'd0, mem[16]}, 64'ha5a5_5a5a);

    // 5: unaligned store
    step();
    r0_set(1'b1, 1'b1, 32'h0000_007a, 32'h1234_5678, 32'h0000_3010);
    step();
    @(negedge clk);
    chk("s5_ack", {63'd0, bus.r0_ack}, 64'd1);
`ifdef DM_ARB_ALIGN_CHK_EN
    chk("s5_err", {63'd0, bus.r0_err}, 64'd1);
    chk("s5_memwrite", {63'd0, bus.MemWrite}, 64'd0);
    chk("s5_rdata", {32'd0, bus.r0_rdata}, 64'd0);
`else
    chk("s5_err", {63'd0, bus.r0_err}, 64'd0);
    chk("s5_memwrite", {63'd0, bus.MemWrite}, 64'd1);
    chk("s5_memaddr", {32'd0, bus.MemAddr}, 64'h7a);
`endif
    $display("txn s5 r0 store addr=%h err=%b", bus.MemAddr, bus.r0_err);
    step();
    r0_set(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    // 6: ten quiet cycles
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_quiet($sformatf("s6_c%0d", c));
      chk($sformatf("s6_hold_c%0d", c), {60'd0, dut.r_hold_cnt}, 64'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
